// File: rtl/hamming_pkg.sv
// Shared Hamming code definitions: codeword/data widths and the rx
// deserializer state encoding. Used by the encoder, decoder and deserializer.
package hamming_pkg;

  // Codeword width for P parity bits
  function automatic int cw_width(input int p);
    return (1 << p) - 1;
  endfunction

  // Data bits carried by a codeword with P parity bits
  function automatic int data_width(input int p);
    return (1 << p) - p - 1;
  endfunction

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } rx_state_e;

endpackage

// File: rtl/hamming_rx_deserializer.sv
// Serial-to-parallel front end for the Hamming decoder: gathers MSB-first
// bits into N-bit codewords and offers them on a valid/ready port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bit_in/bit_valid/bit_ready/frame_start   serial side
//   rx_msg/rx_valid/rx_ready word side (rx_msg[N-1] = first bit)
//   drop_pulse               partial word discarded by frame_start
module hamming_rx_deserializer
  import hamming_pkg::*;
#(
  parameter int P = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  input  logic                   frame_start,
  output logic [cw_width(P)-1:0] rx_msg,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   drop_pulse
);

  localparam int N  = cw_width(P);
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  rx_state_e      state;
  logic [N-1:0]   sr;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           take;
  logic           slot_free;
  logic           last_bit;
  logic [N-1:0]   sr_shift;
  logic [N-1:0]   sr_first;

  // The shift register doubles as the second word buffer while stalled,
  // so the serial side only stops once both buffers hold whole words.
  assign bit_ready = (state == FILL);
  assign accept    = bit_valid & bit_ready;
  assign take      = rx_valid & rx_ready;
  assign slot_free = ~rx_valid | rx_ready;
  assign last_bit  = (cnt == LAST);
  assign sr_shift  = {sr[N-2:0], bit_in};
  assign sr_first  = {{(N-1){1'b0}}, bit_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      sr         <= '0;
      cnt        <= '0;
      rx_msg     <= '0;
      rx_valid   <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        FILL: begin
          // A take empties the slot unless a new word lands below.
          if (take) begin
            rx_valid <= 1'b0;
          end
          if (accept) begin
            if (frame_start) begin
              // Restart alignment; N >= 3 so this bit never completes.
              sr         <= sr_first;
              cnt        <= ONE;
              drop_pulse <= (cnt != '0);
            end else if (last_bit) begin
              sr  <= sr_shift;
              cnt <= '0;
              if (slot_free) begin
                rx_msg   <= sr_shift;
                rx_valid <= 1'b1;
              end else begin
                state <= STALL;
              end
            end else begin
              sr  <= sr_shift;
              cnt <= cnt + ONE;
            end
          end
        end
        STALL: begin
          // rx_valid stays high: the held word moves straight in.
          if (take) begin
            rx_msg <= sr;
            state  <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
